// File: rtl/hc595_chain_driver.sv
// Serial front end for a daisy chain of N_BYTES 74HC595s: shifts a W-bit frame, pulses RCLK, enables outputs.
// Optional read-back check of QH' against the previous frame when HC595_LOOPBACK_EN is defined.
module hc595_chain_driver #(
  parameter int N_BYTES   = 2,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1,
  localparam int W        = 8 * N_BYTES
) (
  input  logic         s_clk,
  input  logic         s_reset,
  input  logic [W-1:0] data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         busy,
  output logic         ser_out,
  output logic         srclk_out,
  output logic         rclk_out,
  output logic         oe_n_out,
  output logic         done_pulse
`ifdef HC595_LOOPBACK_EN
  ,
  input  logic         ser_in,
  output logic         loop_err
`endif
);
  localparam int BW = $clog2(W + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {IDLE, SH_LO, SH_HI, LATCH} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [W-1:0]   sr_q;
  logic           div_last, accept, last_bit;

  // Bit that goes out next, and the register after one bit has left.
  function automatic logic head_bit(input logic [W-1:0] v);
    return (MSB_FIRST != 0) ? v[W-1] : v[0];
  endfunction

  function automatic logic [W-1:0] shift_w(input logic [W-1:0] v);
    return (MSB_FIRST != 0) ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
  endfunction

  assign div_last = (div_cnt == DW'(1));
  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign last_bit = (bit_cnt == BW'(1));

  always_ff @(posedge s_clk or posedge s_reset) begin
    if (s_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept)   state_d = SH_LO;
      SH_LO: if (div_last) state_d = SH_HI;
      SH_HI: if (div_last) state_d = last_bit ? LATCH : SH_LO;
      LATCH: if (div_last) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_clk or posedge s_reset) begin
    if (s_reset) begin
      div_cnt    <= DW'(CLK_DIV);
      bit_cnt    <= '0;
      sr_q       <= '0;
      ser_out    <= 1'b0;
      srclk_out  <= 1'b0;
      rclk_out   <= 1'b0;
      oe_n_out   <= 1'b1;
      done_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      // Divider reloads on every state change so each state lasts CLK_DIV cycles.
      if (state_d != state_q) div_cnt <= DW'(CLK_DIV);
      else if (!div_last)     div_cnt <= div_cnt - DW'(1);
      case (state_q)
        IDLE: if (accept) begin
          sr_q    <= data_in;
          bit_cnt <= BW'(W);
          ser_out <= head_bit(data_in);
          busy    <= 1'b1;
        end
        SH_LO: if (div_last) srclk_out <= 1'b1;
        SH_HI: if (div_last) begin
          srclk_out <= 1'b0;
          bit_cnt   <= bit_cnt - BW'(1);
          if (!last_bit) begin
            sr_q    <= shift_w(sr_q);
            ser_out <= head_bit(shift_w(sr_q));
          end else begin
            rclk_out <= 1'b1;
          end
        end
        LATCH: if (div_last) begin
          rclk_out   <= 1'b0;
          oe_n_out   <= 1'b0;
          done_pulse <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef HC595_LOOPBACK_EN
  // cmp_q walks the previous frame in send order; QH' of the last device should replay it.
  logic [W-1:0] prev_q, cmp_q;
  logic         have_prev, chk_q, mis_q;

  always_ff @(posedge s_clk or posedge s_reset) begin
    if (s_reset) begin
      prev_q    <= '0;
      cmp_q     <= '0;
      have_prev <= 1'b0;
      chk_q     <= 1'b0;
      mis_q     <= 1'b0;
      loop_err  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          prev_q <= data_in;
          cmp_q  <= prev_q;
          chk_q  <= have_prev;
          mis_q  <= 1'b0;
        end
        SH_LO: if (div_last && (ser_in != head_bit(cmp_q))) mis_q <= 1'b1;
        SH_HI: if (div_last && !last_bit) cmp_q <= shift_w(cmp_q);
        LATCH: if (div_last) begin
          loop_err  <= chk_q & mis_q;
          have_prev <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
